// File: rtl/d_latch_with_reset_pkg.sv
// d_latch_with_reset_pkg: shared defaults for the gated D latch primitive
package d_latch_with_reset_pkg;
   localparam int  DEFAULT_WIDTH  = 1;
   localparam bit  LATCH_INTENDED = 1'b1;
endpackage

// File: rtl/d_latch_with_reset.sv
// d_latch_with_reset: level-sensitive gated D latch with async active-high clear
module d_latch_with_reset
   import d_latch_with_reset_pkg::*;
#(
   parameter int              WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit              WAIVE_LATCH = LATCH_INTENDED
) (
   input  logic [WIDTH-1:0] d,
   input  logic             e,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);
   if (WAIVE_LATCH) begin : g_latch
      // reset dominates; transparent while e is high, holds while e is low
      always_latch begin
         if (reset) q <= RESET_VALUE;
         else if (e) q <= d;
      end
   end else begin : g_plain
      // same storage described without the intent-declaring construct
      always @* begin
         if (reset) q = RESET_VALUE;
         else if (e) q = d;
      end
   end
endmodule

// File: tb/tb_d_latch_with_reset.sv
// tb_d_latch_with_reset: randomized and directed checks of the gated D latch
module tb_d_latch_with_reset;
   logic [7:0] d8;
   logic       e, reset;
   logic [7:0] q8;
   logic       q1;
   logic [7:0] m8;
   logic       m1;
   int         checks = 0;
   int         failures = 0;
   logic       clk = 1'b0;

   always #5 clk = ~clk;

   d_latch_with_reset #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_w8 (
      .d(d8), .e(e), .reset(reset), .q(q8)
   );
   d_latch_with_reset u_w1 (
      .d(d8[0]), .e(e), .reset(reset), .q(q1)
   );

   // apply one input vector, let it settle, and advance the reference model
   task automatic drive(input logic r, input logic en, input logic [7:0] dv);
      reset = r;
      e     = en;
      d8    = dv;
      #1;
      if (r) begin
         m8 = 8'hA5;
         m1 = 1'b0;
      end else if (en) begin
         m8 = dv;
         m1 = dv[0];
      end
      #1;
   endtask

   task automatic test_reset;
      drive(1, 1, 8'hFF);
      checks++;
      if (q8 !== 8'hA5 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_dominance q8=%h q1=%b want q8=a5 q1=0", q8, q1);
      end
      drive(1, 1, 8'h00);
      drive(1, 1, 8'hFF);
      checks++;
      if (q8 !== 8'hA5 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold_d_toggle q8=%h q1=%b want q8=a5 q1=0", q8, q1);
      end
   endtask

   task automatic test_reset_release;
      drive(1, 1, 8'hFF);
      reset = 1'b0;
      #0;
      checks++;
      if (q8 !== 8'hFF || q1 !== 1'b1) begin
         failures++;
         $display("FAIL release_transparent_same_step q8=%h q1=%b want q8=ff q1=1", q8, q1);
      end
      #1;
      m8 = 8'hFF;
      m1 = 1'b1;
   endtask

   task automatic test_transparency;
      drive(0, 1, 8'hFF);
      checks++;
      if (q8 !== 8'hFF || q1 !== 1'b1) begin
         failures++;
         $display("FAIL transparent_d1 q8=%h q1=%b want q8=ff q1=1", q8, q1);
      end
      drive(0, 1, 8'h00);
      checks++;
      if (q8 !== 8'h00 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL transparent_d0 q8=%h q1=%b want q8=00 q1=0", q8, q1);
      end
      drive(0, 1, 8'h3C);
      checks++;
      if (q8 !== 8'h3C || q1 !== 1'b0) begin
         failures++;
         $display("FAIL transparent_3c q8=%h q1=%b want q8=3c q1=0", q8, q1);
      end
   endtask

   task automatic test_hold;
      drive(0, 1, 8'hFF);
      drive(0, 0, 8'hFF);
      checks++;
      if (q8 !== 8'hFF || q1 !== 1'b1) begin
         failures++;
         $display("FAIL hold_capture q8=%h q1=%b want q8=ff q1=1", q8, q1);
      end
      drive(0, 0, 8'h00);
      checks++;
      if (q8 !== 8'hFF || q1 !== 1'b1) begin
         failures++;
         $display("FAIL hold_ignore_d q8=%h q1=%b want q8=ff q1=1", q8, q1);
      end
      drive(0, 1, 8'h00);
      checks++;
      if (q8 !== 8'h00 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL hold_reopen q8=%h q1=%b want q8=00 q1=0", q8, q1);
      end
   endtask

   task automatic test_async_clear;
      drive(0, 1, 8'hFF);
      drive(0, 0, 8'hFF);
      drive(1, 0, 8'hFF);
      checks++;
      if (q8 !== 8'hA5 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL clear_while_holding q8=%h q1=%b want q8=a5 q1=0", q8, q1);
      end
      drive(0, 0, 8'hFF);
      checks++;
      if (q8 !== 8'hA5 || q1 !== 1'b0) begin
         failures++;
         $display("FAIL release_opaque q8=%h q1=%b want q8=a5 q1=0", q8, q1);
      end
      drive(0, 1, 8'hFF);
      checks++;
      if (q8 !== 8'hFF || q1 !== 1'b1) begin
         failures++;
         $display("FAIL reopen_after_clear q8=%h q1=%b want q8=ff q1=1", q8, q1);
      end
   endtask

   task automatic test_param;
      drive(1, 0, 8'h00);
      checks++;
      if (q8 !== 8'hA5) begin
         failures++;
         $display("FAIL param_reset_value q8=%h want a5", q8);
      end
      drive(0, 0, 8'h00);
      drive(0, 1, 8'h3C);
      drive(0, 0, 8'h3C);
      drive(0, 0, 8'hFF);
      checks++;
      if (q8 !== 8'h3C || q1 !== 1'b0) begin
         failures++;
         $display("FAIL param_hold_3c q8=%h q1=%b want q8=3c q1=0", q8, q1);
      end
   endtask

   // change exactly one input per step so e never falls alongside d or reset
   task automatic test_random;
      logic       r, en;
      logic [7:0] dv;
      r  = reset;
      en = e;
      dv = d8;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0:       r  = ~r;
            1:       en = ~en;
            default: dv = 8'($urandom);
         endcase
         drive(r, en, dv);
         checks++;
         if (q8 !== m8 || q1 !== m1) begin
            failures++;
            $display("FAIL random_step%0d q8=%h q1=%b want q8=%h q1=%b", i, q8, q1, m8, m1);
         end
      end
   endtask

   initial begin
      d8 = 8'h00;
      e = 1'b0;
      reset = 1'b0;
      m8 = 8'hA5;
      m1 = 1'b0;
      test_reset();
      test_reset_release();
      test_transparency();
      test_hold();
      test_async_clear();
      test_param();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
